// File: rtl/march_pkg.sv
// Shared encodings for the alien march sequencer and its helpers.
// Also imported by the alien-fire scheduler.
package march_pkg;

  localparam logic [1:0] SHIFT_RIGHT = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_DOWN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_LANDED,
    ST_CLEARED
  } march_state_e;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alive_bounds.sv
// Combinational extent and population of the alive formation.
// lcol/rcol/brow are 0 when nothing is alive; qualify with any_alive.
module alive_bounds
  import march_pkg::*;
#(
  parameter  int X_NUM_BLOCKS = 5,
  parameter  int Y_NUM_BLOCKS = 4,
  localparam int N  = X_NUM_BLOCKS * Y_NUM_BLOCKS,
  localparam int CW = idx_w(X_NUM_BLOCKS),
  localparam int RW = idx_w(Y_NUM_BLOCKS),
  localparam int NW = $clog2(N + 1)
) (
  input  logic [N-1:0]  alive_mask,
  output logic [CW-1:0] lcol,
  output logic [CW-1:0] rcol,
  output logic [RW-1:0] brow,
  output logic [NW-1:0] cnt,
  output logic          any_alive
);

  logic [X_NUM_BLOCKS-1:0] col_any;
  logic [Y_NUM_BLOCKS-1:0] row_any;

  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < Y_NUM_BLOCKS; r++) begin
      for (int c = 0; c < X_NUM_BLOCKS; c++) begin
        if (alive_mask[r*X_NUM_BLOCKS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    lcol = '0;
    rcol = '0;
    brow = '0;
    cnt  = '0;
    for (int c = X_NUM_BLOCKS - 1; c >= 0; c--)
      if (col_any[c]) lcol = CW'(c);
    for (int c = 0; c < X_NUM_BLOCKS; c++)
      if (col_any[c]) rcol = CW'(c);
    for (int r = 0; r < Y_NUM_BLOCKS; r++)
      if (row_any[r]) brow = RW'(r);
    for (int i = 0; i < N; i++)
      cnt = cnt + NW'(alive_mask[i]);
  end

  assign any_alive = |alive_mask;

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march sequencer: tick divider, step choice,
// req/ack step handshake, landing and cleared detection.
module alien_march_ctrl
  import march_pkg::*;
#(
  parameter  int X_SIZE       = 8,
  parameter  int Y_SIZE       = 10,
  parameter  int X_NUM_BLOCKS = 5,
  parameter  int Y_NUM_BLOCKS = 4,
  parameter  int DIV_SHIFT    = 2,
  parameter  int MAX_DIV      = 8,
  localparam int N  = X_NUM_BLOCKS * Y_NUM_BLOCKS,
  localparam int XW = $clog2(X_SIZE),
  localparam int YW = $clog2(Y_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          block_tick,
  input  logic          start,
  input  logic [N-1:0]  alive_mask,
  output logic          shift_req,
  output logic [1:0]    shift_dir,
  input  logic          shift_ack,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          dir_left,
  output logic          busy,
  output logic          landed,
  output logic          cleared
);

  localparam int CW = idx_w(X_NUM_BLOCKS);
  localparam int RW = idx_w(Y_NUM_BLOCKS);
  localparam int NW = $clog2(N + 1);
  localparam int DW = $clog2(MAX_DIV + 1);

  march_state_e state_q, state_d;

  logic [CW-1:0] lcol, rcol;
  logic [RW-1:0] brow;
  logic [NW-1:0] cnt;
  logic          any_alive;

  logic [DW-1:0] tick_cnt;
  logic [DW-1:0] div;
  logic          tick_hit;
  logic          at_right, at_left;
  logic [1:0]    step_next;
  logic          land_hit;

  alive_bounds #(
    .X_NUM_BLOCKS(X_NUM_BLOCKS),
    .Y_NUM_BLOCKS(Y_NUM_BLOCKS)
  ) u_bounds (
    .alive_mask(alive_mask),
    .lcol      (lcol),
    .rcol      (rcol),
    .brow      (brow),
    .cnt       (cnt),
    .any_alive (any_alive)
  );

  always_comb begin
    div = DW'(MAX_DIV);
    if (int'(cnt >> DIV_SHIFT) + 1 < MAX_DIV)
      div = DW'(int'(cnt >> DIV_SHIFT) + 1);
  end

  assign tick_hit =
    block_tick && (int'(tick_cnt) + 1 >= int'(div));

  assign at_right =
    (int'(x_off) + int'(rcol)) == (X_SIZE - 1);
  assign at_left =
    (int'(x_off) + int'(lcol)) == 0;

  always_comb begin
    step_next = dir_left ? SHIFT_LEFT : SHIFT_RIGHT;
    if ((!dir_left && at_right) || (dir_left && at_left))
      step_next = SHIFT_DOWN;
  end

  // Judged on the post-step row, i.e. y_off + 1.
  assign land_hit = (shift_dir == SHIFT_DOWN) &&
    (int'(y_off) + 1 + int'(brow) >= Y_SIZE - 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (!any_alive)    state_d = ST_CLEARED;
          else if (tick_hit) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (shift_ack)
            state_d = land_hit ? ST_LANDED : ST_WAIT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_req = 1'b0;
    busy      = 1'b0;
    landed    = 1'b0;
    cleared   = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE:    ;
      state_q == ST_WAIT:    busy = 1'b1;
      state_q == ST_REQ: begin
        busy      = 1'b1;
        shift_req = 1'b1;
      end
      state_q == ST_LANDED:  landed  = 1'b1;
      state_q == ST_CLEARED: cleared = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_off     <= '0;
      y_off     <= '0;
      dir_left  <= 1'b0;
      tick_cnt  <= '0;
      shift_dir <= SHIFT_RIGHT;
    end else if (start) begin
      x_off    <= '0;
      y_off    <= '0;
      dir_left <= 1'b0;
      tick_cnt <= '0;
    end else if (state_q == ST_WAIT && any_alive && block_tick) begin
      if (tick_hit) begin
        tick_cnt  <= '0;
        shift_dir <= step_next;
      end else begin
        tick_cnt <= tick_cnt + DW'(1);
      end
    end else if (state_q == ST_REQ && shift_ack) begin
      unique case (shift_dir)
        SHIFT_RIGHT: x_off <= x_off + XW'(1);
        SHIFT_LEFT:  x_off <= x_off - XW'(1);
        SHIFT_DOWN: begin
          y_off    <= y_off + YW'(1);
          dir_left <= ~dir_left;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Scoreboard bench for alien_march_ctrl: a reference model of the
// formation predicts each step, checked when shift_req appears.
module tb_alien_march_ctrl;
  import march_pkg::*;

  localparam int XN = 5;
  localparam int YN = 4;
  localparam int N  = XN * YN;
  localparam logic [N-1:0] FULL = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          block_tick = 1'b0;
  logic          start = 1'b0;
  logic          shift_ack = 1'b0;
  logic [N-1:0]  alive_mask = '0;
  logic          shift_req;
  logic [1:0]    shift_dir;
  logic [2:0]    x_off;
  logic [3:0]    y_off;
  logic          dir_left, busy, landed, cleared;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  int m_x, m_y, m_tick;
  bit m_left, m_landed;

  always #5 clk = ~clk;

  alien_march_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .block_tick(block_tick),
    .start     (start),
    .alive_mask(alive_mask),
    .shift_req (shift_req),
    .shift_dir (shift_dir),
    .shift_ack (shift_ack),
    .x_off     (x_off),
    .y_off     (y_off),
    .dir_left  (dir_left),
    .busy      (busy),
    .landed    (landed),
    .cleared   (cleared)
  );

  task automatic check_eq(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void bounds(output int lc, output int rc,
                                 output int br, output int cn);
    lc = XN; rc = 0; br = 0; cn = 0;
    for (int r = 0; r < YN; r++)
      for (int c = 0; c < XN; c++)
        if (alive_mask[r*XN+c]) begin
          cn++;
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > br) br = r;
        end
  endfunction

  function automatic int div_of(int cn);
    int d;
    d = 1 + (cn >> 2);
    return (d > 8) ? 8 : d;
  endfunction

  function automatic logic [1:0] exp_dir(int lc, int rc);
    if (!m_left && m_x + rc == 7) return SHIFT_DOWN;
    if (m_left && m_x + lc == 0) return SHIFT_DOWN;
    return m_left ? SHIFT_LEFT : SHIFT_RIGHT;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_x = 0; m_y = 0; m_tick = 0;
    m_left = 0; m_landed = 0;
    exp_q.delete();
    check_eq("start_busy", busy, 1);
    check_eq("start_req", shift_req, 0);
    check_eq("start_xoff", x_off, 0);
    check_eq("start_yoff", y_off, 0);
    check_eq("start_left", dir_left, 0);
    check_eq("start_landed", landed, 0);
    check_eq("start_cleared", cleared, 0);
  endtask

  task automatic idle_ticks(int n);
    for (int i = 0; i < n; i++) begin
      block_tick = 1'b1;
      @(negedge clk);
      block_tick = 1'b0;
      @(negedge clk);
      check_eq("idle_no_req", shift_req, 0);
      check_eq("idle_busy", busy, 0);
    end
  endtask

  task automatic tick_once(output bit hit);
    int lc, rc, br, cn;
    bounds(lc, rc, br, cn);
    hit = 1'b0;
    if (m_tick + 1 >= div_of(cn)) begin
      hit = 1'b1;
      m_tick = 0;
      exp_q.push_back(exp_dir(lc, rc));
    end else begin
      m_tick++;
    end
    block_tick = 1'b1;
    @(negedge clk);
    block_tick = 1'b0;
    check_eq("req_after_tick", shift_req, hit);
  endtask

  task automatic march_step(int hold);
    bit hit;
    int guard;
    int lc, rc, br, cn;
    logic [1:0] d;
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 16) begin
      tick_once(hit);
      guard++;
    end
    if (!hit) check_eq("req_timeout", shift_req, 1);
    d = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b11;
    check_eq("shift_dir", shift_dir, d);
    for (int i = 0; i < hold; i++) begin
      block_tick = (i % 2 == 0);
      @(negedge clk);
      block_tick = 1'b0;
      check_eq("hold_req", shift_req, 1);
      check_eq("hold_dir", shift_dir, d);
      check_eq("hold_xoff", x_off, m_x);
      check_eq("hold_yoff", y_off, m_y);
    end
    shift_ack = 1'b1;
    @(negedge clk);
    shift_ack = 1'b0;
    case (d)
      SHIFT_RIGHT: m_x++;
      SHIFT_LEFT:  m_x--;
      default: begin
        m_y++;
        m_left = !m_left;
        bounds(lc, rc, br, cn);
        if (m_y + br >= 8) m_landed = 1'b1;
      end
    endcase
    check_eq("ack_req_drop", shift_req, 0);
    check_eq("ack_xoff", x_off, m_x);
    check_eq("ack_yoff", y_off, m_y);
    check_eq("ack_left", dir_left, m_left);
    check_eq("ack_landed", landed, m_landed);
    check_eq("ack_busy", busy, !m_landed);
  endtask

  initial begin
    bit h;
    int guard;
    alive_mask = FULL;
    repeat (3) @(negedge clk);
    check_eq("rst_req", shift_req, 0);
    check_eq("rst_dir", shift_dir, 0);
    check_eq("rst_xoff", x_off, 0);
    check_eq("rst_yoff", y_off, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_landed", landed, 0);
    check_eq("rst_cleared", cleared, 0);
    rst = 1'b1;
    @(negedge clk);
    idle_ticks(3);

    // Reset asserted mid-request must drop everything at once.
    do_start();
    h = 1'b0;
    guard = 0;
    while (!h && guard < 16) begin
      tick_once(h);
      guard++;
    end
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_req", shift_req, 0);
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_ticks(8);
    check_eq("post_rst_xoff", x_off, 0);

    // Full formation: R,R(held ack),R,D then left, down to landing.
    do_start();
    march_step(0);
    march_step(5);
    march_step(0);
    march_step(0);
    check_eq("first_down_y", y_off, 1);
    check_eq("first_down_left", dir_left, 1);
    check_eq("first_down_x", x_off, 3);
    guard = 0;
    while (!m_landed && guard < 40) begin
      march_step(0);
      guard++;
    end
    check_eq("land_yoff", y_off, 5);
    check_eq("land_flag", landed, 1);
    check_eq("land_busy", busy, 0);
    idle_ticks(10);
    check_eq("land_sticky", landed, 1);

    // Single alien: one step per tick, full sweep right then left.
    alive_mask = '0;
    alive_mask[0] = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) march_step(0);
    check_eq("sweep_x", x_off, 0);
    check_eq("sweep_y", y_off, 2);
    check_eq("sweep_left", dir_left, 0);

    // Clear while waiting, then restart.
    alive_mask = '0;
    @(negedge clk);
    check_eq("clr_flag", cleared, 1);
    check_eq("clr_busy", busy, 0);
    idle_ticks(3);
    alive_mask = FULL;
    do_start();
    march_step(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alien_march_ctrl.md
Name: alien_march_ctrl

Overview:
Sequences the alien formation across the board state matrix. It counts block_clk ticks, chooses each formation step (right, left or down), and issues that step to the state-matrix datapath over a req/ack handshake. The step rate speeds up as aliens are destroyed. It reports landing (formation reached the player row) and cleared (no aliens left) to the game top level.

Parameters:
X_SIZE, 8, board width in cells
Y_SIZE, 10, board height in cells; row Y_SIZE-1 is the player row
X_NUM_BLOCKS, 5, formation width in aliens (must be <= X_SIZE)
Y_NUM_BLOCKS, 4, formation height in aliens (must be < Y_SIZE-1)
DIV_SHIFT, 2, alive-count right-shift used for the speed divider
MAX_DIV, 8, maximum ticks per step

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
block_tick  in  1  one-clk pulse per block_clk period, synchronous to clk
start  in  1  one-clk pulse: (re)initialise and begin marching
alive_mask  in  X_NUM_BLOCKS*Y_NUM_BLOCKS  alive bit per alien; bit r*X_NUM_BLOCKS+c, row 0 is the top row
shift_req  out  1  step request to the state matrix
shift_dir  out  2  step direction: 00 right, 01 left, 10 down
shift_ack  in  1  state matrix has applied the step
x_off  out  $clog2(X_SIZE)  board column of formation column 0
y_off  out  $clog2(Y_SIZE)  board row of formation row 0
dir_left  out  1  current horizontal direction (0 = right)
busy  out  1  high in WAIT or REQ
landed  out  1  sticky; formation reached the player row
cleared  out  1  sticky; alive_mask became all zero

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0. Tick counter 0.
- FSM states: IDLE, WAIT, REQ, LANDED, CLEARED.
- start (any state): x_off=0, y_off=0, dir_left=0, tick_cnt=0, landed=0, cleared=0, state WAIT. Outputs reflect this on the next cycle. start overrides all other events in the same cycle, including shift_ack; an aborted request is dropped.
- Combinational bounds, computed from alive_mask:
  - lcol and rcol: leftmost and rightmost alive columns.
  - brow: bottom alive row.
  - cnt: alive count.
- Divider: div = min(MAX_DIV, 1 + (cnt >> DIV_SHIFT)), sampled on each tick.
- WAIT:
  - If alive_mask==0, go to CLEARED and set cleared=1. This check has priority over ticks.
  - On block_tick: if tick_cnt+1 >= div, set tick_cnt=0 and go to REQ; otherwise tick_cnt++.
- Step choice, latched on entry to REQ:
  - If dir_left=0 and x_off+rcol == X_SIZE-1, choose down.
  - Else if dir_left=1 and x_off+lcol == 0, choose down.
  - Otherwise choose right or left per dir_left.
- REQ handshake:
  - shift_req=1, with shift_dir stable, until shift_ack is sampled high.
  - On ack: shift_req drops the next cycle and the offset updates the next cycle.
    - right: x_off+1.
    - left: x_off-1.
    - down: y_off+1 and dir_left toggles.
  - block_tick pulses during REQ are discarded.
  - shift_ack outside REQ is ignored.
- After a down ack: if y_off_new + brow >= Y_SIZE-2, go to LANDED with landed=1. Otherwise return to WAIT.
- LANDED and CLEARED are terminal; only start or reset leaves them. busy=0 in both.
- No wrap-around: the edge rule prevents x_off from leaving 0..X_SIZE-X_NUM_BLOCKS+(X_NUM_BLOCKS-1-rcol).

Decomposition:
- Shared package march_pkg, containing:
  - shift_dir encodings SHIFT_RIGHT=2'b00, SHIFT_LEFT=2'b01, SHIFT_DOWN=2'b10;
  - FSM state encodings.
- One sub-module, alive_bounds: purely combinational.
  - Input: alive_mask.
  - Outputs: lcol, rcol, brow, cnt, any_alive.
  - Shared later with the alien-fire scheduler.

Test Plan:
- Reset/idle: rst low mid-REQ, then high, with ticks applied. Required: shift_req=0, x_off=0, y_off=0, busy=0; no request until start.
- Full formation: mask all 1 (cnt=20, div=6), start, ack each request immediately.
  - Each request follows exactly 6 ticks.
  - Directions are right, right, right, then down, since 3+4=7.
  - After the down step: y_off=1, dir_left=1; the next step is left.
- Speed-up and edge: mask only column 0, row 0 alive (cnt=1, div=1).
  - A request follows every tick.
  - Moving right continues until x_off=7, then down, then left to x_off=0, then down.
- Handshake hold: delay shift_ack by 5 cycles and send 3 ticks meanwhile. Required: shift_req and shift_dir remain stable; offset changes once; the ticks are discarded, so tick_cnt=0 afterwards.
- Landing: full mask, run until y_off=5 (5+3=8). Required: landed=1, state LANDED, no further shift_req, busy=0.
- Clear and restart: drive mask to 0 in WAIT. Required: cleared=1 the next cycle. Then pulse start with the full mask: cleared=0, offsets 0, marching resumes.
